// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, datapath
// mux selects, ALU operation classes, immediate formats and opcodes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALWB    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_CMP   = 2'b11;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHIFT = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/multicycle_controller_branch_resolve.sv
// Branch condition evaluation from funct3 and the ALU zero/less-than flags.
module branch_resolve (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       taken
);

    // Signedness of lt is chosen upstream through unsign, so bltu/bgeu match blt/bge here.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = lt;
            3'b111:  taken = ~lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: one state per cycle, memory
// req/ready handshake with a bounded wait counter, sticky trap on faults.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       unsign,
    output logic       retire,
    output logic       trap,
    output logic       trap_cause,
    output logic [3:0] state
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              trap_flag;
    logic              trap_code;
    logic              trap_enter;
    logic              trap_set_cause;
    logic              timeout;
    logic              taken;

    branch_resolve u_branch_resolve (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .taken  (taken)
    );

    // The current cycle is the WAIT_LIMIT-th unanswered one; a same-cycle ready wins.
    assign timeout = ~mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state  <= S_FETCH;
            wait_cnt   <= '0;
            trap_flag  <= 1'b0;
            trap_code  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state || mem_ready || !mem_req)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (trap_enter) begin
                trap_flag <= 1'b1;
                trap_code <= trap_set_cause;
            end
        end
    end

    always_comb begin
        nxt_state      = cur_state;
        trap_enter     = 1'b0;
        trap_set_cause = 1'b0;
        mem_req        = 1'b0;
        MemWrite       = 1'b0;
        AdrSrc         = 1'b0;
        IRWrite        = 1'b0;
        PCWrite        = 1'b0;
        RegWrite       = 1'b0;
        ResultSrc      = RES_ALUOUT;
        ALUSrcA        = SRCA_PC;
        ALUSrcB        = SRCB_RS2;
        ALUOp          = ALU_ADD;
        ImmSrc         = IMM_I;
        unsign         = 1'b0;
        retire         = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) begin
                    nxt_state = S_DECODE;
                end else if (timeout) begin
                    nxt_state      = S_TRAP;
                    trap_enter     = 1'b1;
                    trap_set_cause = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: nxt_state = S_MEMADR;
                    OP_RTYPE:          nxt_state = S_EXECR;
                    OP_ITYPE:          nxt_state = S_EXECI;
                    OP_BRANCH:         nxt_state = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            nxt_state = S_JAL;
                    OP_JALR:           nxt_state = S_JALR;
                    OP_LUI:            nxt_state = S_LUI;
                    OP_AUIPC:          nxt_state = S_AUIPC;
                    default:           nxt_state = S_TRAP;
                endcase
                trap_enter = (nxt_state == S_TRAP);
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = (op == OP_STORE) ? IMM_S : IMM_I;
                nxt_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_MEMWB;
                end else if (timeout) begin
                    nxt_state      = S_TRAP;
                    trap_enter     = 1'b1;
                    trap_set_cause = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end else if (timeout) begin
                    nxt_state      = S_TRAP;
                    trap_enter     = 1'b1;
                    trap_set_cause = 1'b1;
                end
            end
            S_EXECR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOp     = ALU_FUNCT;
                unsign    = (funct3 == 3'b011);
                nxt_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALU_FUNCT;
                unsign    = (funct3 == 3'b011);
                ImmSrc    = (funct3[1:0] == 2'b01) ? IMM_SHIFT : IMM_I;
                nxt_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA   = SRCA_ZERO;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_U;
                nxt_state = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_U;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ResultSrc = RES_ALUOUT;
                ALUOp     = funct3[2] ? ALU_CMP : ALU_SUB;
                unsign    = funct3[1] & funct3[2];
                PCWrite   = taken;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_J;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
                nxt_state = S_JALWB;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_I;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
                nxt_state = S_JALWB;
            end
            S_JALWB: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_TRAP: begin
                nxt_state = S_TRAP;
            end
            default: begin
                nxt_state = S_FETCH;
            end
        endcase
    end

    assign state      = cur_state;
    assign trap       = trap_flag;
    assign trap_cause = trap_code;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (WAIT_LIMIT = 4).
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       unsign;
    logic       retire;
    logic       trap;
    logic       trap_cause;
    logic [3:0] state;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    multicycle_controller #(.WAIT_LIMIT(4), .WAIT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .unsign     (unsign),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic set_in(input logic [6:0] o, input logic [2:0] f,
                          input logic z, input logic l, input logic r);
        op = o; funct3 = f; zero = z; lt = l; mem_ready = r;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        assert_cnt++;
        if (state !== 4'd0) begin fail_cnt++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        assert_cnt++;
        if (trap !== 1'b0 || trap_cause !== 1'b0) begin
            fail_cnt++; $display("[TB] FAIL reset_trap got %b/%b want 0/0", trap, trap_cause);
        end
        assert_cnt++;
        if (mem_req !== 1'b1 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
            fail_cnt++;
            $display("[TB] FAIL reset_fetch_outs got req=%b ir=%b pc=%b srcb=%b res=%b want 1 0 0 10 10",
                     mem_req, IRWrite, PCWrite, ALUSrcB, ResultSrc);
        end
    endtask

    task automatic test_add();
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
            assert_cnt++;
            if (state !== exp_st[i]) begin fail_cnt++; $display("[TB] FAIL add_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
            assert_cnt++;
            if (RegWrite !== (i == 3) || retire !== (i == 3)) begin
                fail_cnt++; $display("[TB] FAIL add_wb[%0d] got rw=%b ret=%b want %0d", i, RegWrite, retire, i == 3);
            end
            if (i == 2) begin
                assert_cnt++;
                if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00 || ALUOp !== 2'b10) begin
                    fail_cnt++; $display("[TB] FAIL add_exec got a=%b b=%b op=%b want 10 00 10", ALUSrcA, ALUSrcB, ALUOp);
                end
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp_st [8];
        logic       rdy [8];
        int         ir_cnt = 0;
        int         rw_early = 0;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(7'b0000011, 3'b010, 1'b0, 1'b0, rdy[i]);
            assert_cnt++;
            if (state !== exp_st[i]) begin fail_cnt++; $display("[TB] FAIL lw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
            if (i >= 3 && i <= 6) begin
                assert_cnt++;
                if (mem_req !== 1'b1 || AdrSrc !== 1'b1) begin
                    fail_cnt++; $display("[TB] FAIL lw_memread[%0d] got req=%b adr=%b want 1 1", i, mem_req, AdrSrc);
                end
            end
            ir_cnt += int'(IRWrite);
            if (i < 7) rw_early += int'(RegWrite);
            if (i == 7) begin
                assert_cnt++;
                if (RegWrite !== 1'b1 || retire !== 1'b1 || ResultSrc !== 2'b01) begin
                    fail_cnt++; $display("[TB] FAIL lw_memwb got rw=%b ret=%b res=%b want 1 1 01", RegWrite, retire, ResultSrc);
                end
            end
            tick();
        end
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        assert_cnt++;
        if (state !== 4'd0) begin fail_cnt++; $display("[TB] FAIL lw_done_state got %0d want 0", state); end
        assert_cnt++;
        if (ir_cnt !== 1) begin fail_cnt++; $display("[TB] FAIL lw_irwrite_count got %0d want 1", ir_cnt); end
        assert_cnt++;
        if (rw_early !== 0) begin fail_cnt++; $display("[TB] FAIL lw_early_regwrite got %0d want 0", rw_early); end
    endtask

    task automatic run_branch(input logic [2:0] f, input logic z, input logic l,
                              input logic exp_pcw, input logic exp_uns, input logic [1:0] exp_aluop);
        do_reset();
        set_in(7'b1100011, f, z, l, 1'b1);
        tick();
        set_in(7'b1100011, f, z, l, 1'b1);
        tick();
        set_in(7'b1100011, f, z, l, 1'b1);
        assert_cnt++;
        if (state !== 4'd9) begin fail_cnt++; $display("[TB] FAIL br%b_state got %0d want 9", f, state); end
        assert_cnt++;
        if (PCWrite !== exp_pcw || unsign !== exp_uns || ALUOp !== exp_aluop || retire !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL br%b_outs got pcw=%b uns=%b aluop=%b ret=%b want %b %b %b 1",
                     f, PCWrite, unsign, ALUOp, retire, exp_pcw, exp_uns, exp_aluop);
        end
        tick();
        set_in(7'b1100011, f, z, l, 1'b0);
        assert_cnt++;
        if (state !== 4'd0) begin fail_cnt++; $display("[TB] FAIL br%b_return got %0d want 0", f, state); end
    endtask

    task automatic test_branch();
        run_branch(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        run_branch(3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
        run_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        run_branch(3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11);
    endtask

    task automatic test_jal();
        logic [3:0] exp_st [4];
        exp_st = '{4'd0, 4'd1, 4'd10, 4'd12};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
            assert_cnt++;
            if (state !== exp_st[i]) begin fail_cnt++; $display("[TB] FAIL jal_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
            if (i == 2) begin
                assert_cnt++;
                if (PCWrite !== 1'b1 || ImmSrc !== 3'b011 || RegWrite !== 1'b0) begin
                    fail_cnt++; $display("[TB] FAIL jal_jump got pcw=%b imm=%b rw=%b want 1 011 0", PCWrite, ImmSrc, RegWrite);
                end
            end
            if (i == 3) begin
                assert_cnt++;
                if (RegWrite !== 1'b1 || retire !== 1'b1 || ALUSrcB !== 2'b10) begin
                    fail_cnt++; $display("[TB] FAIL jal_wb got rw=%b ret=%b b=%b want 1 1 10", RegWrite, retire, ALUSrcB);
                end
            end
            tick();
        end
    endtask

    task automatic run_illegal(input logic [6:0] o, input logic [2:0] f);
        int not_trap = 0;
        do_reset();
        set_in(o, f, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(o, f, 1'b0, 1'b0, 1'b1);
        assert_cnt++;
        if (state !== 4'd1) begin fail_cnt++; $display("[TB] FAIL ill_%b_decode got %0d want 1", o, state); end
        tick();
        for (int i = 0; i < 20; i++) begin
            set_in(o, f, 1'b0, 1'b0, 1'b1);
            if (state !== 4'd15 || trap !== 1'b1 || trap_cause !== 1'b0 || mem_req !== 1'b0 || retire !== 1'b0)
                not_trap++;
            tick();
        end
        assert_cnt++;
        if (not_trap !== 0) begin fail_cnt++; $display("[TB] FAIL ill_%b_hold got %0d bad cycles want 0", o, not_trap); end
        do_reset();
        assert_cnt++;
        if (state !== 4'd0 || trap !== 1'b0) begin
            fail_cnt++; $display("[TB] FAIL ill_%b_clear got st=%0d trap=%b want 0 0", o, state, trap);
        end
    endtask

    task automatic test_illegal();
        run_illegal(7'b0000000, 3'b000);
        run_illegal(7'b1100011, 3'b010);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
            assert_cnt++;
            if (state !== 4'd0 || trap !== 1'b0) begin
                fail_cnt++; $display("[TB] FAIL to_wait[%0d] got st=%0d trap=%b want 0 0", i, state, trap);
            end
            tick();
        end
        set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        assert_cnt++;
        if (state !== 4'd15 || trap !== 1'b1 || trap_cause !== 1'b1) begin
            fail_cnt++; $display("[TB] FAIL to_trap got st=%0d trap=%b cause=%b want 15 1 1", state, trap, trap_cause);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
        assert_cnt++;
        if (state !== 4'd0 || IRWrite !== 1'b1) begin
            fail_cnt++; $display("[TB] FAIL to_limit_ready got st=%0d ir=%b want 0 1", state, IRWrite);
        end
        tick();
        set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
        assert_cnt++;
        if (state !== 4'd1 || trap !== 1'b0) begin
            fail_cnt++; $display("[TB] FAIL to_no_trap got st=%0d trap=%b want 1 0", state, trap);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [3:0] exp_st [5];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(7'b0100011, 3'b010, 1'b0, 1'b0, (i < 2));
            assert_cnt++;
            if (state !== exp_st[i]) begin fail_cnt++; $display("[TB] FAIL sw_state[%0d] got %0d want %0d", i, state, exp_st[i]); end
            if (i == 2) begin
                assert_cnt++;
                if (ImmSrc !== 3'b001) begin fail_cnt++; $display("[TB] FAIL sw_immsrc got %b want 001", ImmSrc); end
            end
            if (i >= 3) begin
                assert_cnt++;
                if (MemWrite !== 1'b1 || retire !== 1'b0) begin
                    fail_cnt++; $display("[TB] FAIL sw_wait[%0d] got mw=%b ret=%b want 1 0", i, MemWrite, retire);
                end
            end
            if (i < 4) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        assert_cnt++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || retire !== 1'b0) begin
            fail_cnt++; $display("[TB] FAIL sw_reset got st=%0d mw=%b ret=%b want 0 0 0", state, MemWrite, retire);
        end
    endtask

    initial begin
        reset = 1'b1; op = '0; funct3 = '0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I core variant. Datapath: one shared instruction/data memory, IR/OldPC/ALUOut/Data registers, one ALU.
- Decodes the opcode held in IR and sequences the datapath one state per cycle.
- Handles wait states through a req/ready memory handshake and a bounded wait counter.
- Flags illegal encodings and memory timeouts through a sticky trap.

Parameters:
- WAIT_LIMIT, 255, maximum consecutive cycles mem_req may stay unanswered before trapping (1..255).
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- zero  in  1  ALU result == 0.
- lt  in  1  ALU less-than; signed or unsigned per the unsign output.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  the access is a write.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = sub (beq/bne), 10 = funct-decoded, 11 = compare.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 shift-I.
- unsign  out  1  unsigned compare.
- retire  out  1  one-cycle pulse in the final state of each instruction.
- trap  out  1  sticky fault flag.
- trap_cause  out  1  0 = illegal instruction, 1 = memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- Reset: state = FETCH, wait counter = 0, trap = 0, trap_cause = 0. Default outputs are 0 in every state unless listed below. Reset mid-instruction abandons it; the next cycle is a FETCH.
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7.
  - ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALWB 12, LUI 13, AUIPC 14, TRAP 15.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are combinational: equal to mem_ready. They go to 1 only in the cycle mem_ready=1.
  - Leave for DECODE only when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010 (ALUOut = branch target). Next state by op:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 0110111 → LUI.
  - 0010111 → AUIPC.
  - Anything else → TRAP with cause 0.
  - A branch with funct3 = 010 or 011 also → TRAP with cause 0.
- MEMADR: ALUSrcA=10, ALUSrcB=01. ImmSrc=001 if store, else 000. Next state is MEMWRITE for a store, MEMREAD for a load.
- MEMREAD: mem_req=1, AdrSrc=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next state FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. On mem_ready: retire=1 and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, unsign=(funct3==011). Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, unsign=(funct3==011). ImmSrc=101 if funct3[1:0]==01, else 000. Next state ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=100. Next state ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=100. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next state FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ResultSrc=00.
  - ALUOp=01 if funct3[2]=0, else 11. unsign=funct3[1]&funct3[2].
  - PCWrite = taken, where taken is: beq zero; bne !zero; blt/bltu lt; bge/bgeu !lt.
  - retire=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=01, ImmSrc=011, ResultSrc=10, PCWrite=1. Next state JALWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ResultSrc=10, PCWrite=1. Next state JALWB. The datapath clears bit 0 of the target.
- JALWB: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1, retire=1. Next state FETCH.
- Latency with zero wait states:
  - lw 5 cycles; sw, R, I, lui, auipc 4 cycles; branch 3 cycles; jal/jalr 4 cycles.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Counts consecutive cycles with mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on any state change.
  - When it reaches WAIT_LIMIT with mem_ready still 0: go to TRAP with cause 1. mem_ready in the same cycle wins over the timeout.
- TRAP: all strobes 0, mem_req=0. Stays in TRAP until reset. trap=1 and trap_cause remain held.

Decomposition:
- Shared package: state encodings; ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings; opcode constants.
- One natural sub-module, `branch_resolve`: combinational, takes funct3/zero/lt and produces taken.

Test Plan:
- add x3,x1,x2 with mem_ready always 1 → states 0,1,6,8,0; RegWrite=1 only in state 8; retire pulse at cycle 4.
- lw with mem_ready low for 3 cycles during MEMREAD → lw takes 8 cycles total; no RegWrite before MEMWB; IRWrite exactly once.
- beq with zero=1 → PCWrite=1 in BRANCH. bgeu with lt=1 → PCWrite=0 and unsign=1. Both take 3 cycles.
- op=0000000 or a branch with funct3=010 → TRAP after DECODE; trap=1, trap_cause=0; holds 20 cycles; reset returns to FETCH with trap=0.
- mem_ready held 0 in FETCH with WAIT_LIMIT=4 → TRAP 4 cycles later with trap_cause=1. Repeat with mem_ready=1 on the limit cycle → no trap.
- Assert reset during MEMWRITE wait → next cycle FETCH, MemWrite=0, no retire pulse.
